spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
- Parametrised SPI master, successor to the fixed 32-bit/2-slave master.
- Generic word width, slave-select count and SPI clock divider; all four CPOL/CPHA modes; busy flag; programmable SS idle gap.
- Sits between on-chip control logic (din/trigger/dout/valid) and external SPI peripherals on the imager board.

Parameters:
DATA_WIDTH, 32, bits per transfer (>=2)
NUM_SS, 2, number of active-low slave selects (>=1)
CLK_DIV, 2, CLK_IN cycles per SPI_CLK half-period (>=1)
SS_IDLE_CYCLES, 2, CLK_IN cycles SS stays high after a transfer before next accept (>=1)
TGT_W, max(1,clog2(NUM_SS)), derived width of target

Ports:
CLK_IN  input  1  system clock, all logic on rising edge
RST_IN  input  1  asynchronous, active-high reset
din  input  DATA_WIDTH  word to transmit
trigger  input  1  start request, sampled when busy=0
target  input  TGT_W  binary index of slave to select
CPOL  input  1  SPI clock idle level
CPHA  input  1  0: sample leading edge; 1: sample trailing edge
dout  output  DATA_WIDTH  last received word
valid  output  1  one-cycle pulse, dout updated
busy  output  1  transfer or SS idle gap in progress
MOSI  output  1  serial data out
MISO  input  1  serial data in
SPI_CLK  output  1  serial clock
SPI_SS  output  NUM_SS  active-low selects, one-cold during transfer

Behaviour:
- Reset (async, RST_IN=1): SPI_SS all 1, SPI_CLK=0, MOSI=0, dout=0, valid=0, busy=0, state IDLE, counters 0. Asserting mid-transfer aborts immediately; no valid.
- IDLE: SPI_CLK registered from live CPOL each cycle; MOSI=0.
- Accept: trigger=1 in IDLE, target<NUM_SS -> latch din, target, CPOL, CPHA into shadow regs; inputs ignored afterwards until IDLE. target>=NUM_SS: request dropped, no SS, busy stays 0, no valid.
- trigger while busy=1 ignored (not queued).
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
- Cycle after accept: busy=1, SPI_SS[target]=0, state LEAD. CPHA=0: MOSI = first bit now. CPHA=1: MOSI unchanged until first edge.
- LEAD lasts CLK_DIV cycles; then SHIFT toggles SPI_CLK every CLK_DIV cycles, exactly 2*DATA_WIDTH toggles, ending at CPOL.
- CPHA=0: odd toggles (leading) sample MISO into shift reg on the toggle cycle; even toggles except the last drive next MOSI bit.
- CPHA=1: odd toggles drive next MOSI bit; even toggles sample MISO.
- Bit order MSB first (default build).
- TRAIL: CLK_DIV cycles after last toggle; then SPI_SS all 1, dout <= received word, valid=1 for one cycle, MOSI=0, state GAP.
- GAP: SS_IDLE_CYCLES cycles, then busy=0, IDLE.
- busy high for exactly (2*DATA_WIDTH+2)*CLK_DIV + SS_IDLE_CYCLES cycles per accepted transfer.
- Counters saturate-free: half-period counter wraps 0..CLK_DIV-1, edge counter 0..2*DATA_WIDTH-1.
- dout holds value between valid pulses.

Optional Feature:
- Macro SPI_LSB_FIRST_EN. Defined: extra input port lsb_first (1 bit), latched at accept; 1 -> transmit din[0] first and receive first bit into dout[0]; 0 -> MSB first. Undefined: no port, always MSB first, identical timing.

Test Plan:
- DATA_WIDTH=32, CLK_DIV=2, NUM_SS=2, MISO looped to MOSI, CPOL=0 CPHA=0, din=0xAAAA3333, target=1 -> 64 SPI_CLK toggles, SPI_SS=2'b01 during transfer, dout=0xAAAA3333, single valid pulse, busy 134 cycles.
- Same loopback, modes (0,1)=0xBBBB4444, (1,1)=0xCCCC5555, (1,0)=0xDDDD6666 -> dout matches each; SPI_CLK idles at CPOL before/after; MOSI stable on every sampling edge.
- Slave model returns 0x12345678 independent of MOSI, mode 1 -> dout=0x12345678, slave captured din exactly.
- trigger pulsed again 20 cycles into a transfer with din=0xFFFFFFFF -> ignored, dout from first word only, one valid.
- NUM_SS=3, target=3 -> no SS asserted, busy=0, no valid; RST_IN=1 mid-transfer -> SS all 1, SPI_CLK=0, busy=0 same cycle, no valid.
- SPI_LSB_FIRST_EN defined, lsb_first=1, din=0x00000001, loopback -> MOSI high on first bit only, dout=0x00000001.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with generic word width, slave-select
// count, SPI clock divider and slave-select idle gap. Supports all four CPOL/CPHA modes.
// Optional build macro SPI_LSB_FIRST_EN adds the lsb_first input; it selects LSB-first
// shifting per transfer. Without the macro, transfers are always MSB first and timing
// is unchanged.
//
// state | meaning
// IDLE  | waiting for trigger; SPI_CLK follows live CPOL, MOSI low
// LEAD  | SS asserted, one half-period before the first SPI_CLK edge
// SHIFT | 2*DATA_WIDTH SPI_CLK toggles, one every CLK_DIV cycles
// TRAIL | one half-period after the last edge, SS still asserted
// GAP   | SS released, SS_IDLE_CYCLES before the next request is accepted
module spi_master_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SS         = 2,
    parameter int CLK_DIV        = 2,
    parameter int SS_IDLE_CYCLES = 2,
    parameter int TGT_W          = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  CLK_IN,
    input  logic                  RST_IN,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  trigger,
    input  logic [TGT_W-1:0]      target,
    input  logic                  CPOL,
    input  logic                  CPHA,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  busy,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  SPI_CLK,
    output logic [NUM_SS-1:0]     SPI_SS
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
    localparam int GAP_W  = (SS_IDLE_CYCLES > 1) ? $clog2(SS_IDLE_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  mosi_q, mosi_d;
    logic                  sclk_q, sclk_d;
    logic [NUM_SS-1:0]     ss_q, ss_d;

    logic [NUM_SS-1:0]     ss_sel;
    logic                  lsb_in;
    logic                  target_ok;
    logic                  half_done;
    logic                  last_edge;
    logic                  do_sample;
    logic                  do_drive;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic lsb, input logic b);
        return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
    endfunction

    assign target_ok = (32'(target) < 32'(NUM_SS));
    assign half_done = (div_q == DIV_W'(CLK_DIV - 1));
    assign last_edge = (edge_q == EDGE_W'(2 * DATA_WIDTH - 1));
    // edge_q holds (toggle number - 1): even edge_q is a leading toggle
    assign do_sample = cpha_q ? edge_q[0] : ~edge_q[0];
    assign do_drive  = cpha_q ? ~edge_q[0] : (edge_q[0] & ~last_edge);

    // Decode the binary target index into a one-cold slave-select pattern
    always_comb begin
        ss_sel = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (32'(target) == 32'(i)) ss_sel[i] = 1'b0;
        end
    end

    // Next-state logic for the transfer sequencer and its datapath
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;

        case (state_q)
            S_IDLE: begin
                sclk_d = CPOL;
                mosi_d = 1'b0;
                if (trigger && target_ok) begin
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    lsb_d   = lsb_in;
                    busy_d  = 1'b1;
                    ss_d    = ss_sel;
                    div_d   = '0;
                    edge_d  = '0;
                    rx_d    = '0;
                    state_d = S_LEAD;
                    if (!CPHA) begin
                        mosi_d = first_bit(din, lsb_in);
                        tx_d   = shift_out(din, lsb_in);
                    end else begin
                        tx_d   = din;
                    end
                end
            end
            S_LEAD: begin
                div_d = div_q + DIV_W'(1);
                if (half_done) begin
                    div_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                div_d = div_q + DIV_W'(1);
                if (half_done) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (do_sample) rx_d = shift_in(rx_q, lsb_q, MISO);
                    if (do_drive) begin
                        mosi_d = first_bit(tx_q, lsb_q);
                        tx_d   = shift_out(tx_q, lsb_q);
                    end
                    if (last_edge) begin
                        edge_d  = '0;
                        state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                div_d = div_q + DIV_W'(1);
                if (half_done) begin
                    div_d   = '0;
                    ss_d    = '1;
                    dout_d  = rx_q;
                    valid_d = 1'b1;
                    mosi_d  = 1'b0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(SS_IDLE_CYCLES - 1)) begin
                    gap_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ss_d    = '1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer without a valid pulse
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            gap_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ss_q    <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign MOSI    = mosi_q;
    assign SPI_CLK = sclk_q;
    assign SPI_SS  = ss_q;

endmodule
